wb_arbiter: RTL and testbench
=============================

// Module: wb_arbiter
// PURPOSE
//  Writeback merge stage that sits directly upstream of the register file's single write port.
//  - Port A: the in-order ALU pipe, 1-cycle results, no backpressure.
//  - Port B: long-latency units (load/mul/div), valid/ready.
//  B results wait in a DEPTH-entry FIFO; A always has priority. A starvation guard drains the FIFO.
//  Registered output drives regfile wen/regWAddr/regWData; pending[] feeds the hazard unit.
// PARAMETERS
//  XLEN          32  data width
//  DEPTH         4   FIFO entries for port B (power of 2, >=2)
//  STARVE_LIMIT  8   consecutive lost cycles of a live FIFO head before a_stall is raised (>=1)
// PORTS
//  clk        in   1      clock, rising edge
//  reset      in   1      asynchronous, active-high reset
//  a_valid    in   1      port A result valid (ALU pipe)
//  a_rd       in   5      port A destination register
//  a_data     in   XLEN   port A result
//  a_stall    out  1      request: ALU pipe must hold a_valid=0 next cycle... see BEHAVIOUR
//  b_valid    in   1      port B result valid
//  b_ready    out  1      port B accept (= !full && !reset)
//  b_rd       in   5      port B destination register
//  b_data     in   XLEN   port B result
//  wen        out  1      regfile write enable (registered)
//  regWAddr   out  5      regfile write address (registered)
//  regWData   out  XLEN   regfile write data (registered)
//  pending    out  32     bit r=1: a live (non-stale) FIFO entry targets r; bit 0 always 0
// BEHAVIOUR
//  Reset (async): wen=0, regWAddr=0, regWData=0, FIFO empty, starve count=0, a_stall=0, b_ready=0 while reset high.
//   Mid-operation reset discards all queued entries; nothing is written.
//  B accept: b_valid&&b_ready. An entry with b_rd==0 is accepted and dropped (not queued).
//  Output mux each cycle, priority order:
//   1. a_valid && a_rd!=0 -> wen<=1, addr/data from A.
//   2. Else live FIFO head -> written, popped.
//   3. Else FIFO empty and B accept this cycle -> B written directly (bypass, no queue).
//   4. Else wen<=0 (addr/data hold).
//   a_valid with a_rd==0 is ignored and does not block B.
//  Latency: A 1 cycle; B 1 cycle if bypassed, else queued in strict FIFO order.
//  WAW kill: when A writes rd X, every queued entry with rd X is marked stale. A same-cycle B push
//   is younger and is not marked stale.
//  Stale head pops every cycle without using the write port, including cycles where A writes.
//  Push and pop in the same cycle are allowed. No push when full: b_ready=0, even if a pop occurs that cycle.
//  Starve counter: +1 each cycle the head is live and A wins; cleared on head pop or empty.
//   a_stall = (count==STARVE_LIMIT), registered.
//   When a_stall=1 the ALU pipe must present a_valid=0 that cycle; the head is written and the count clears.
//   a_valid=1 during a_stall is a protocol violation: A still wins (assertion in bench).
//  pending: combinational from FIFO live bits. Entries already in the output register are excluded;
//   the regfile's own bypass covers them.
// TESTING
//  1. After reset: b_ready=0 while reset high; wen=0. Release reset -> b_ready=1.
//  2. Bypass: FIFO empty, B (rd=5, 0xDEAD) alone -> next cycle wen=1, regWAddr=5, regWData=0xDEAD; pending stays 0.
//  3. Priority/queue: A and B both valid, rd 3 and 7 -> A written first, then B the next cycle.
//     pending[7]=1 for exactly 1 cycle.
//  4. Fill: block FIFO drain with continuous A writes; push 4 B -> b_ready=0.
//     A pauses one cycle -> 1 pop; b_ready=1 again the following cycle.
//  5. WAW: queue B rd=9; A writes rd=9 value 0x11 -> stale entry pops with no write;
//     r9 ends at 0x11; pending[9] clears the cycle after the A write.
//  6. Starvation: FIFO live, A valid every cycle -> a_stall=1 after 8 losses.
//     A drops valid -> head written; count=0, a_stall=0.

Source files
------------

// File: rtl/wb_arbiter.sv
// Writeback merge in front of the single regfile write port: ALU port A has priority,
// long-latency port B results queue in a small FIFO with WAW kill and a starvation guard.
module wb_arbiter #(
  parameter int XLEN         = 32,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            a_valid,
  input  logic [4:0]      a_rd,
  input  logic [XLEN-1:0] a_data,
  output logic            a_stall,
  input  logic            b_valid,
  output logic            b_ready,
  input  logic [4:0]      b_rd,
  input  logic [XLEN-1:0] b_data,
  output logic            wen,
  output logic [4:0]      regWAddr,
  output logic [XLEN-1:0] regWData,
  output logic [31:0]     pending
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]      r_fifo_rd   [DEPTH];
  logic [XLEN-1:0] r_fifo_data [DEPTH];
  logic [DEPTH-1:0] r_live;
  logic [AW:0]     r_wptr, r_rptr;
  logic [CW-1:0]   r_cnt;
  logic            r_stall;
  logic            r_wen;
  logic [4:0]      r_addr;
  logic [XLEN-1:0] r_data;

  logic [AW-1:0]   w_widx, w_ridx;
  logic            w_empty, w_full, w_head_live;
  logic            w_a_win, w_b_acc, w_b_keep, w_bypass, w_push, w_pop;
  logic [DEPTH-1:0] w_live_n;
  logic [CW-1:0]   w_cnt_n;
  logic            w_wen_n;
  logic [4:0]      w_addr_n;
  logic [XLEN-1:0] w_data_n;
  logic [31:0]     w_pending;

  assign w_widx      = r_wptr[AW-1:0];
  assign w_ridx      = r_rptr[AW-1:0];
  assign w_empty     = (r_wptr == r_rptr);
  assign w_full      = (r_wptr[AW] != r_rptr[AW]) && (w_widx == w_ridx);
  assign w_head_live = !w_empty && r_live[w_ridx];

  assign w_a_win  = a_valid && (a_rd != 5'd0);
  assign b_ready  = !w_full && !reset;
  assign w_b_acc  = b_valid && b_ready;
  // rd==0 results are accepted but never reach the regfile or the queue
  assign w_b_keep = w_b_acc && (b_rd != 5'd0);
  assign w_bypass = !w_a_win && w_empty && w_b_keep;
  assign w_push   = w_b_keep && !w_bypass;
  // a stale head leaves every cycle; a live head only when A is idle
  assign w_pop    = !w_empty && (!r_live[w_ridx] || !w_a_win);

  always_comb begin
    w_wen_n  = 1'b0;
    w_addr_n = r_addr;
    w_data_n = r_data;
    if (w_a_win) begin
      w_wen_n  = 1'b1;
      w_addr_n = a_rd;
      w_data_n = a_data;
    end else if (w_head_live) begin
      w_wen_n  = 1'b1;
      w_addr_n = r_fifo_rd[w_ridx];
      w_data_n = r_fifo_data[w_ridx];
    end else if (w_bypass) begin
      w_wen_n  = 1'b1;
      w_addr_n = b_rd;
      w_data_n = b_data;
    end
  end

  // Kill older writes to the same rd before the push so the younger B entry survives
  always_comb begin
    w_live_n = r_live;
    if (w_a_win) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (r_fifo_rd[i] == a_rd) w_live_n[i] = 1'b0;
      end
    end
    if (w_pop)  w_live_n[w_ridx] = 1'b0;
    if (w_push) w_live_n[w_widx] = 1'b1;
  end

  always_comb begin
    w_cnt_n = r_cnt;
    if (w_empty || w_pop)
      w_cnt_n = '0;
    else if (w_head_live && w_a_win && (r_cnt != CW'(STARVE_LIMIT)))
      w_cnt_n = r_cnt + CW'(1);
  end

  always_comb begin
    w_pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_live[i]) w_pending[r_fifo_rd[i]] = 1'b1;
    end
    w_pending[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_live  <= '0;
      r_cnt   <= '0;
      r_stall <= 1'b0;
      r_wen   <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      r_live  <= w_live_n;
      r_cnt   <= w_cnt_n;
      r_stall <= (w_cnt_n == CW'(STARVE_LIMIT));
      r_wen   <= w_wen_n;
      r_addr  <= w_addr_n;
      r_data  <= w_data_n;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_rd[w_widx]   <= b_rd;
      r_fifo_data[w_widx] <= b_data;
    end
  end

  assign a_stall  = r_stall;
  assign wen      = r_wen;
  assign regWAddr = r_addr;
  assign regWData = r_data;
  assign pending  = w_pending;
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: reset, bypass, priority, fill, WAW kill, starvation, rd0, mid-reset.
module tb_wb_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        a_valid, b_valid;
  logic [4:0]  a_rd, b_rd;
  logic [31:0] a_data, b_data;
  logic        a_stall, b_ready, wen;
  logic [4:0]  regWAddr;
  logic [31:0] regWData;
  logic [31:0] pending;

  int tests = 0;
  int fails = 0;
  logic [31:0] rf [32];

  wb_arbiter #(.XLEN(32), .DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_stall(a_stall),
    .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
    .wen(wen), .regWAddr(regWAddr), .regWData(regWData), .pending(pending)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // regfile model driven by the write port, plus protocol watch on a_stall
  always @(posedge clk) begin
    if (wen) rf[regWAddr] <= regWData;
    if (!reset && a_stall && a_valid) begin
      fails++;
      $display("FAIL protocol: a_valid=1 while a_stall=1");
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_valid = 0; a_rd = 0; a_data = 0;
    b_valid = 0; b_rd = 0; b_data = 0;
  endtask

  task automatic chk_w(string name, logic exp_wen, logic [4:0] exp_a, logic [31:0] exp_d);
    tests++;
    if (wen !== exp_wen || (exp_wen && (regWAddr !== exp_a || regWData !== exp_d))) begin
      fails++;
      $display("FAIL %s: wen=%0b addr=%0d data=%h, want wen=%0b addr=%0d data=%h",
               name, wen, regWAddr, regWData, exp_wen, exp_a, exp_d);
    end
  endtask

  task automatic test_reset();
    reset = 1; idle();
    #1;
    tests++;
    if (b_ready !== 1'b0 || wen !== 1'b0 || regWAddr !== 5'd0 || regWData !== 32'd0 || a_stall !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: b_ready=%0b wen=%0b addr=%0d data=%h stall=%0b, want all 0",
               b_ready, wen, regWAddr, regWData, a_stall);
    end
    tick(); tick();
    reset = 0;
    #1;
    tests++;
    if (b_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_release: b_ready=%0b want 1", b_ready);
    end
  endtask

  task automatic test_bypass();
    b_valid = 1; b_rd = 5; b_data = 32'hDEAD;
    tick();
    idle();
    chk_w("bypass_write", 1, 5, 32'hDEAD);
    tests++;
    if (pending !== 32'd0) begin
      fails++;
      $display("FAIL bypass_pending: pending=%h want 0", pending);
    end
    tick();
    chk_w("bypass_idle", 0, 0, 0);
  endtask

  task automatic test_priority();
    a_valid = 1; a_rd = 3; a_data = 32'h333;
    b_valid = 1; b_rd = 7; b_data = 32'h777;
    tick();
    idle();
    chk_w("prio_a_first", 1, 3, 32'h333);
    tests++;
    if (pending !== 32'h0000_0080) begin
      fails++;
      $display("FAIL prio_pending_set: pending=%h want 00000080", pending);
    end
    tick();
    chk_w("prio_b_second", 1, 7, 32'h777);
    tests++;
    if (pending !== 32'd0) begin
      fails++;
      $display("FAIL prio_pending_clr: pending=%h want 0", pending);
    end
    tick();
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (b_ready !== 1'b1) begin
        fails++;
        $display("FAIL fill_ready_%0d: b_ready=%0b want 1", i, b_ready);
      end
      a_valid = 1; a_rd = 2; a_data = 32'h200 + i;
      b_valid = 1; b_rd = 5'(10 + i); b_data = 32'hB0 + i;
      tick();
    end
    b_valid = 0;
    tests++;
    if (b_ready !== 1'b0 || pending !== 32'h0000_3C00) begin
      fails++;
      $display("FAIL fill_full: b_ready=%0b pending=%h, want 0 and 00003c00", b_ready, pending);
    end
    // pause A; offer a B that must be refused even though a pop happens
    a_valid = 0; b_valid = 1; b_rd = 20; b_data = 32'hBAD;
    #1;
    tests++;
    if (b_ready !== 1'b0) begin
      fails++;
      $display("FAIL fill_no_push_on_pop: b_ready=%0b want 0", b_ready);
    end
    tick();
    b_valid = 0;
    chk_w("fill_pop0", 1, 10, 32'hB0);
    tests++;
    if (b_ready !== 1'b1) begin
      fails++;
      $display("FAIL fill_ready_again: b_ready=%0b want 1", b_ready);
    end
    tick(); chk_w("fill_pop1", 1, 11, 32'hB1);
    tick(); chk_w("fill_pop2", 1, 12, 32'hB2);
    tick(); chk_w("fill_pop3", 1, 13, 32'hB3);
    tick(); chk_w("fill_no_refused", 0, 0, 0);
  endtask

  task automatic test_waw();
    a_valid = 1; a_rd = 1; a_data = 32'h100;
    b_valid = 1; b_rd = 9; b_data = 32'h99;
    tick();
    tests++;
    if (pending !== 32'h0000_0200) begin
      fails++;
      $display("FAIL waw_pending_set: pending=%h want 00000200", pending);
    end
    a_valid = 1; a_rd = 9; a_data = 32'h11; b_valid = 0;
    tick();
    idle();
    chk_w("waw_a_write", 1, 9, 32'h11);
    tests++;
    if (pending !== 32'd0) begin
      fails++;
      $display("FAIL waw_pending_clr: pending=%h want 0", pending);
    end
    tick(); chk_w("waw_stale_pop", 0, 0, 0);
    tick(); chk_w("waw_after", 0, 0, 0);
    tests++;
    if (rf[9] !== 32'h11) begin
      fails++;
      $display("FAIL waw_r9: r9=%h want 00000011", rf[9]);
    end
  endtask

  task automatic test_starve();
    a_valid = 1; a_rd = 4; a_data = 32'h44;
    b_valid = 1; b_rd = 6; b_data = 32'h66;
    tick();
    b_valid = 0;
    for (int i = 0; i < 7; i++) tick();
    tests++;
    if (a_stall !== 1'b0) begin
      fails++;
      $display("FAIL starve_early: a_stall=%0b after 7 losses want 0", a_stall);
    end
    tick();
    tests++;
    if (a_stall !== 1'b1) begin
      fails++;
      $display("FAIL starve_raise: a_stall=%0b after 8 losses want 1", a_stall);
    end
    a_valid = 0;
    tick();
    chk_w("starve_head_written", 1, 6, 32'h66);
    tests++;
    if (a_stall !== 1'b0) begin
      fails++;
      $display("FAIL starve_clear: a_stall=%0b want 0", a_stall);
    end
    idle();
    tick();
  endtask

  task automatic test_rd0();
    b_valid = 1; b_rd = 0; b_data = 32'h5;
    tick();
    idle();
    chk_w("rd0_b_drop", 0, 0, 0);
    a_valid = 1; a_rd = 0; a_data = 32'hAA;
    b_valid = 1; b_rd = 8; b_data = 32'h88;
    tick();
    idle();
    chk_w("rd0_a_ignored", 1, 8, 32'h88);
    tick();
  endtask

  task automatic test_midreset();
    a_valid = 1; a_rd = 2; a_data = 32'h22;
    b_valid = 1; b_rd = 14; b_data = 32'hEE;
    tick();
    idle();
    #2 reset = 1;
    #1;
    tests++;
    if (b_ready !== 1'b0 || wen !== 1'b0 || pending !== 32'd0) begin
      fails++;
      $display("FAIL midreset_async: b_ready=%0b wen=%0b pending=%h want 0/0/0", b_ready, wen, pending);
    end
    tick();
    reset = 0;
    tick();
    chk_w("midreset_discard", 0, 0, 0);
  endtask

  initial begin
    for (int r = 0; r < 32; r++) rf[r] = 32'd0;
    test_reset();
    test_bypass();
    test_priority();
    test_fill();
    test_waw();
    test_starve();
    test_rd0();
    test_midreset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
